// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: carry chain split into STAGES segments, one per cycle,
// with valid/ready stall. Optional Overflow/Zero flags are built when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic cin);
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];
  logic [SEG:0]     seg_c [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             cy_nxt[STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             cy_p  [STAGES];
  logic             vld_p [STAGES];

  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p[LAST];

  // Stage inputs: stage 0 from the ports (B inverted for subtract), others from the previous stage.
  always_comb begin
    a_in[0] = A;
    b_in[0] = Sub ? ~B : B;
    s_in[0] = '0;
    c_in[0] = Sub;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_p[k-1];
      b_in[k] = b_p[k-1];
      s_in[k] = s_p[k-1];
      c_in[k] = cy_p[k-1];
      v_in[k] = vld_p[k-1];
    end
  end

  // Each stage resolves its own segment and merges it into the running partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_c[k]                 = seg_add(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
      s_nxt[k]                 = s_in[k];
      s_nxt[k][k*SEG +: SEG]   = seg_c[k][SEG-1:0];
      cy_nxt[k]                = seg_c[k][SEG];
    end
  end

  // ---- stage registers: valid bits ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= v_in[k];
    end
  end

  // ---- stage registers: skewed operands and partial sums ----
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]  <= a_in[k];
        b_p[k]  <= b_in[k];
        s_p[k]  <= s_nxt[k];
        cy_p[k] <= cy_nxt[k];
      end
    end
  end

  // ---- last stage: result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum   <= '0;
      Carry <= 1'b0;
    end else if (advance) begin
      Sum   <= s_nxt[LAST];
      Carry <= cy_nxt[LAST];
    end
  end

`ifdef PIPE_ADDER_FLAGS_EN
  logic ovf_nxt;

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign ovf_nxt = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nxt[LAST][WIDTH-1] ^ cy_nxt[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else if (advance) begin
      Overflow <= ovf_nxt;
      Zero     <= ~|s_nxt[LAST];
    end
  end
`else
  assign Overflow = 1'b0;
  assign Zero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed cases, backpressure, mid-stream reset and random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_pipe_adder;
  localparam int W  = 32;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Sum;
  logic         Carry;
  logic         Overflow;
  logic         Zero;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  res_t q[$];

  pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Carry(Carry), .Overflow(Overflow), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic fl(input logic x);
`ifdef PIPE_ADDER_FLAGS_EN
    fl = x;
`else
    fl = x & 1'b0;
`endif
  endfunction

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t   r;
    longint sa, sb, t, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    t   = sub ? sa - sb : sa + sb;
    lim = longint'(1) << (W - 1);
    r.s = sub ? a - b : a + b;
    r.c = sub ? (a >= b) : ((64'(a) + 64'(b)) >= (64'd1 << W));
    r.o = fl((t >= lim) || (t < -lim));
    r.z = fl(r.s == '0);
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    res_t e;
    if (mon_en) begin
      if (q.size() == 0) chk("no_stale_out", 64'(out_valid), 64'd0);
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_sum",   64'(Sum),      64'(e.s));
        chk("sb_carry", 64'(Carry),    64'(e.c));
        chk("sb_ovf",   64'(Overflow), 64'(e.o));
        chk("sb_zero",  64'(Zero),     64'(e.z));
      end
      if (rst) q.delete();
      else if (in_valid && in_ready) q.push_back(model(A, B, Sub));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int t;
    A = a; B = b; Sub = s; in_valid = 1'b1;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 100) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] es, input logic ec,
                         input logic eo, input logic ez);
    send(a, b, s);
    in_valid = 1'b0;
    for (int i = 1; i <= ST + 2; i++) begin
      @(negedge clk);
      chk({tag, "_vld"}, 64'(out_valid), 64'(i == ST));
      if (i == ST) begin
        chk({tag, "_sum"},   64'(Sum),      64'(es));
        chk({tag, "_carry"}, 64'(Carry),    64'(ec));
        chk({tag, "_ovf"},   64'(Overflow), 64'(fl(eo)));
        chk({tag, "_zero"},  64'(Zero),     64'(fl(ez)));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    held = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(Sum),       64'd0);
    chk("rst_carry",     64'(Carry),     64'd0);
    chk("rst_ovf",       64'(Overflow),  64'd0);
    chk("rst_zero",      64'(Zero),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    run_dir("add5p3",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run_dir("segcarry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_dir("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_dir("sub5m5",  32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_dir("subovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: 8 back-to-back ops, consumer stalls cycles 5..9.
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          if (j == 0) held = Sum;
          else chk("bp_sum_stable", 64'(Sum), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (ST + 12) @(posedge clk);
    #1 chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < ST + 2; i++) begin
      @(negedge clk);
      chk("midrst_quiet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_dir("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Random traffic with random stalls and one reset.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      Sub       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       A = 32'hFFFF_FFFF;
        1:       A = 32'h8000_0000;
        default: A = $urandom;
      endcase
      B   = ($urandom_range(0, 3) == 0) ? A : $urandom;
      rst = (i == 150);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (ST + 4) @(posedge clk);
    #1 chk("final_drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
